// File: rtl/wb_arbiter_if.sv
// Write-back bus between the in-order pipe, the long-latency unit and the register-file arbiter.
// The slave side is the arbiter; the master side is whatever drives the pipe/unit requests.
interface wb_arbiter_if;
    logic        pipe_wr;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        unit_valid;
    logic [4:0]  unit_reg;
    logic [31:0] unit_data;
    logic        unit_ready;
    logic        regWrite;
    logic [4:0]  writeregister;
    logic [31:0] data;
    logic        pipe_stall;
    logic [31:0] pend_mask;
    logic        proto_err;

    modport slave (
        input  pipe_wr, pipe_reg, pipe_data, unit_valid, unit_reg, unit_data,
        output unit_ready, regWrite, writeregister, data, pipe_stall, pend_mask, proto_err
    );

    modport master (
        output pipe_wr, pipe_reg, pipe_data, unit_valid, unit_reg, unit_data,
        input  unit_ready, regWrite, writeregister, data, pipe_stall, pend_mask, proto_err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: pipe writes land 1 cycle later, unit results >=2 cycles via FIFO.
// Backpressure: unit_ready drops while the FIFO is full; a starved FIFO head raises pipe_stall.
module wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   L_DEPTH = FIFO_DEPTH[PW:0];
    localparam logic [SW-1:0] L_LIMIT = STARVE_LIMIT[SW-1:0];

    logic [4:0]    r_mem_reg [FIFO_DEPTH];
    logic [31:0]   r_mem_dat [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [SW-1:0] r_starve;
    logic          r_stall;
    logic          r_reg_write;
    logic [4:0]    r_wreg;
    logic [31:0]   r_wdat;
    logic          r_proto_err;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_push;
    logic          w_sel_pipe;
    logic          w_pop;
    logic [PW:0]   w_count_nxt;
    logic [PW-1:0] w_off;
    logic [31:0]   w_pend;

    // Ready and pop both come from registered occupancy, so nothing bypasses the FIFO.
    assign w_full      = (r_count == L_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_accept    = bus.unit_valid && !w_full;
    assign w_push      = w_accept && (bus.unit_reg != 5'd0);
    assign w_sel_pipe  = bus.pipe_wr && !r_stall;
    assign w_pop       = !w_sel_pipe && !w_empty;
    assign w_count_nxt = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

    always_comb begin
        w_pend = '0;
        w_off  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_off = PW'(i) - r_rd_ptr;
            if ({1'b0, w_off} < r_count) begin
                w_pend[r_mem_reg[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_reg[r_wr_ptr] <= bus.unit_reg;
            r_mem_dat[r_wr_ptr] <= bus.unit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_stall     <= 1'b0;
            r_reg_write <= 1'b0;
            r_wreg      <= '0;
            r_wdat      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_nxt;

            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != L_LIMIT) begin
                r_starve <= r_starve + SW'(1);
            end

            // Stall holds until the FIFO fully drains, even if the counter has cleared.
            if (w_count_nxt == '0) begin
                r_stall <= 1'b0;
            end else if (r_starve == L_LIMIT) begin
                r_stall <= 1'b1;
            end

            if (bus.pipe_wr && r_stall) r_proto_err <= 1'b1;

            r_reg_write <= 1'b0;
            if (w_sel_pipe) begin
                if (bus.pipe_reg != 5'd0) begin
                    r_reg_write <= 1'b1;
                    r_wreg      <= bus.pipe_reg;
                    r_wdat      <= bus.pipe_data;
                end
            end else if (w_pop) begin
                r_reg_write <= 1'b1;
                r_wreg      <= r_mem_reg[r_rd_ptr];
                r_wdat      <= r_mem_dat[r_rd_ptr];
            end
        end
    end

    assign bus.unit_ready    = !w_full;
    assign bus.regWrite      = r_reg_write;
    assign bus.writeregister = r_wreg;
    assign bus.data          = r_wdat;
    assign bus.pipe_stall    = r_stall;
    assign bus.pend_mask     = w_pend;
    assign bus.proto_err     = r_proto_err;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios against fixed expectations, then random traffic
// against a queue-based reference model of the write-back rules.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    wb_arbiter_if bus ();

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    ent_t        m_q[$];
    int          m_starve = 0;
    bit          m_stall  = 0;
    bit          m_rw     = 0;
    bit          m_proto  = 0;
    logic [4:0]  m_wreg   = '0;
    logic [31:0] m_wdat   = '0;

    function automatic logic [72:0] dut_vec();
        return {bus.unit_ready, bus.regWrite, bus.writeregister, bus.data,
                bus.pipe_stall, bus.pend_mask, bus.proto_err};
    endfunction

    function automatic logic [72:0] mdl_vec();
        logic [31:0] p;
        p = '0;
        foreach (m_q[i]) p[m_q[i].r] = 1'b1;
        return {(m_q.size() < DEPTH), m_rw, m_wreg, m_wdat, m_stall, p, m_proto};
    endfunction

    task automatic drive(input bit pw, input logic [4:0] preg, input logic [31:0] pdat,
                         input bit uv, input logic [4:0] ureg, input logic [31:0] udat);
        bus.pipe_wr    = pw;
        bus.pipe_reg   = preg;
        bus.pipe_data  = pdat;
        bus.unit_valid = uv;
        bus.unit_reg   = ureg;
        bus.unit_data  = udat;
    endtask

    // Advance one clock; the reference model consumes the inputs present at the edge.
    task automatic tick();
        bit   sel, pop, acc, at_limit;
        ent_t e;
        if (reset) begin
            m_q.delete();
            m_starve = 0; m_stall = 0; m_rw = 0; m_proto = 0;
            m_wreg = '0; m_wdat = '0;
        end else begin
            acc      = bus.unit_valid && (m_q.size() < DEPTH);
            sel      = bus.pipe_wr && !m_stall;
            pop      = !sel && (m_q.size() != 0);
            at_limit = (m_starve == LIMIT);
            if (bus.pipe_wr && m_stall) m_proto = 1;
            m_rw = 0;
            if (sel) begin
                if (bus.pipe_reg != 0) begin
                    m_rw = 1; m_wreg = bus.pipe_reg; m_wdat = bus.pipe_data;
                end
            end else if (pop) begin
                e = m_q[0];
                m_rw = 1; m_wreg = e.r; m_wdat = e.d;
            end
            if (pop || m_q.size() == 0) m_starve = 0;
            else if (m_starve < LIMIT)  m_starve++;
            if (pop) void'(m_q.pop_front());
            if (acc && bus.unit_reg != 0) begin
                e.r = bus.unit_reg; e.d = bus.unit_data;
                m_q.push_back(e);
            end
            if (m_q.size() == 0) m_stall = 0;
            else if (at_limit)   m_stall = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        vectors++;
        if (dut_vec() !== {1'b1, 72'd0}) begin
            miscompares++;
            $display("FAIL reset_state got %h expected %h", dut_vec(), {1'b1, 72'd0});
        end
        reset = 1'b0;
    endtask

    task automatic test_pipe();
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.regWrite, bus.writeregister, bus.data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL pipe_write got %b/%0d/%h expected 1/5/deadbeef",
                     bus.regWrite, bus.writeregister, bus.data);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.regWrite, bus.writeregister, bus.data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL pipe_idle_hold got %b/%0d/%h expected 0/5/deadbeef",
                     bus.regWrite, bus.writeregister, bus.data);
        end
        drive(1, 5'd0, 32'h55, 0, 0, 0);
        tick();
        vectors++;
        if (bus.regWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL pipe_reg0 got regWrite=%b expected 0", bus.regWrite);
        end
    endtask

    task automatic test_unit_idle();
        drive(0, 0, 0, 1, 5'd9, 32'h1234);
        tick();
        vectors++;
        if ({bus.pend_mask, bus.regWrite} !== {32'h0000_0200, 1'b0}) begin
            miscompares++;
            $display("FAIL unit_pend got mask=%h rw=%b expected 00000200/0", bus.pend_mask, bus.regWrite);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.regWrite, bus.writeregister, bus.data, bus.pend_mask} !==
            {1'b1, 5'd9, 32'h1234, 32'h0}) begin
            miscompares++;
            $display("FAIL unit_write got %b/%0d/%h mask=%h expected 1/9/1234 mask=0",
                     bus.regWrite, bus.writeregister, bus.data, bus.pend_mask);
        end
        drive(0, 0, 0, 1, 5'd0, 32'h77);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if ({bus.regWrite, bus.pend_mask} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL unit_reg0 got rw=%b mask=%h expected 0/0", bus.regWrite, bus.pend_mask);
        end
    endtask

    task automatic test_full_drain();
        logic [4:0] got[$];
        logic [4:0] exp_r;
        bit         acc;
        for (int k = 0; k < 4; k++) begin
            drive(1, 5'd1, 32'(k), 1, 5'(10 + k), 32'hA0 + 32'(k));
            tick();
        end
        vectors++;
        if ({bus.unit_ready, bus.pend_mask} !== {1'b0, 32'h0000_3C00}) begin
            miscompares++;
            $display("FAIL full_ready got ready=%b mask=%h expected 0/00003c00", bus.unit_ready, bus.pend_mask);
        end
        drive(1, 5'd1, 32'h9, 1, 5'd14, 32'hAE);
        tick();
        vectors++;
        if ({bus.unit_ready, bus.pend_mask, bus.regWrite, bus.writeregister} !==
            {1'b0, 32'h0000_3C00, 1'b1, 5'd1}) begin
            miscompares++;
            $display("FAIL full_hold got ready=%b mask=%h rw=%b reg=%0d expected 0/00003c00/1/1",
                     bus.unit_ready, bus.pend_mask, bus.regWrite, bus.writeregister);
        end
        bus.pipe_wr = 1'b0;
        for (int i = 0; i < 12 && got.size() < 5; i++) begin
            acc = bus.unit_valid && bus.unit_ready;
            tick();
            if (acc) bus.unit_valid = 1'b0;
            if (bus.regWrite) got.push_back(bus.writeregister);
            if (i == 0) begin
                vectors++;
                if (bus.unit_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_after_pop got %b expected 1", bus.unit_ready);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            exp_r = 5'(10 + i);
            vectors++;
            if (i >= got.size() || got[i] !== exp_r) begin
                miscompares++;
                $display("FAIL drain_order idx %0d got %0d expected %0d", i,
                         (i < got.size()) ? got[i] : 5'd0, exp_r);
            end
        end
    endtask

    task automatic test_starve();
        drive(1, 5'd3, 32'h33, 1, 5'd20, 32'h2020);
        tick();
        bus.unit_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            vectors++;
            if ({bus.pipe_stall, bus.proto_err} !== {(k == 9), 1'b0}) begin
                miscompares++;
                $display("FAIL starve_wait k=%0d got stall=%b perr=%b expected %b/0",
                         k, bus.pipe_stall, bus.proto_err, (k == 9));
            end
        end
        tick();
        vectors++;
        if ({bus.regWrite, bus.writeregister, bus.data, bus.pipe_stall, bus.proto_err} !==
            {1'b1, 5'd20, 32'h2020, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL starve_release got %b/%0d/%h stall=%b perr=%b expected 1/20/2020/0/1",
                     bus.regWrite, bus.writeregister, bus.data, bus.pipe_stall, bus.proto_err);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd4, 32'h44, 1, 5'(21 + k), 32'hC0 + 32'(k));
            tick();
        end
        bus.unit_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = bus.pipe_stall;
        end
        vectors++;
        if (!seen || bus.pend_mask !== 32'h00E0_0000) begin
            miscompares++;
            $display("FAIL mid_stall got stall=%b mask=%h expected 1/00e00000", bus.pipe_stall, bus.pend_mask);
        end
        reset = 1'b1;
        drive(0, 0, 0, 1, 5'd24, 32'hEE);
        tick();
        vectors++;
        if (dut_vec() !== {1'b1, 72'd0}) begin
            miscompares++;
            $display("FAIL mid_reset got %h expected %h", dut_vec(), {1'b1, 72'd0});
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({bus.regWrite, bus.pend_mask} !== {1'b0, 32'h0}) begin
                miscompares++;
                $display("FAIL mid_discard cyc %0d got rw=%b mask=%h expected 0/0", i, bus.regWrite, bus.pend_mask);
            end
        end
    endtask

    task automatic test_random();
        int busy;
        for (int i = 0; i < 2000; i++) begin
            busy = (i % 500 < 350) ? 85 : 25;
            reset = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 99) < busy), 5'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom());
            tick();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d got %h expected %h", cyc, dut_vec(), mdl_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_pipe();
        test_unit_idle();
        test_full_drain();
        test_starve();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of buffered long-latency write-back entries (power of two, 2..16).
REQ-002 Parameter STARVE_LIMIT, default 8, SHALL set how many consecutive cycles a non-empty FIFO head may wait before the pipe is stalled.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pipe_wr  input  1  in-order pipeline WB stage requests a register write this cycle.
REQ-006 pipe_reg  input  5  pipeline destination register.
REQ-007 pipe_data  input  32  pipeline write data.
REQ-008 unit_valid  input  1  long-latency unit (mult/div/load-miss) offers a result.
REQ-009 unit_reg  input  5  unit destination register.
REQ-010 unit_data  input  32  unit result data.
REQ-011 unit_ready  output  1  FIFO can accept; SHALL be high when not full, and is independent of unit_valid.
REQ-012 regWrite  output  1  registered write enable to the register file.
REQ-013 writeregister  output  5  registered write address.
REQ-014 data  output  32  registered write data.
REQ-015 pipe_stall  output  1  registered; pipeline SHALL hold off WB writes while high.
REQ-016 pend_mask  output  32  bit r set while any FIFO entry targets register r, for decode interlock.
REQ-017 proto_err  output  1  sticky; set when pipe_wr is seen while pipe_stall is high.

Function
REQ-018 A unit transfer SHALL occur on a rising edge where unit_valid and unit_ready are both high.
REQ-019 An accepted unit entry with unit_reg==0 SHALL be consumed without being enqueued.
REQ-020 A pipe request with pipe_reg==0 SHALL produce regWrite=0.
REQ-021 Selection each cycle: if pipe_wr and not pipe_stall, the pipe wins; else a non-empty FIFO head wins; else idle.
REQ-022 Pipe latency SHALL be 1 cycle: a request presented in cycle c appears on regWrite/writeregister/data in cycle c+1.
REQ-023 Unit latency SHALL be at least 2 cycles: an entry accepted in cycle c is selectable no earlier than cycle c+1 and appears no earlier than cycle c+2.
REQ-024 When idle, regWrite SHALL be 0 and writeregister/data SHALL hold their previous values.
REQ-025 The FIFO SHALL drain in acceptance order, and the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 When the FIFO is full and a pop occurs in the same cycle, unit_ready SHALL still be 0 (no full-cycle pass-through).
REQ-027 When the FIFO is empty, a simultaneous accept and selection SHALL NOT bypass the entry; it is popped no earlier than the next cycle.
REQ-028 Starve counter: it SHALL increment each cycle the FIFO is non-empty and its head is not selected.
REQ-029 The starve counter SHALL clear on any pop or when the FIFO is empty, and SHALL saturate at STARVE_LIMIT.
REQ-030 pipe_stall SHALL assert the cycle after the counter reaches STARVE_LIMIT, and SHALL deassert the cycle after the FIFO becomes empty.
REQ-031 While pipe_stall is high, pipe_wr SHALL be ignored and SHALL set proto_err.
REQ-032 pend_mask SHALL be the OR of the one-hot destinations of all valid FIFO entries, updated in the same cycle as each push or pop.
REQ-033 Pushes and pops to the same register in the same cycle SHALL leave the bit set while any entry for that register remains.
REQ-034 Multiple FIFO entries for the same register SHALL be permitted, and the last write wins at the register file.

Reset
REQ-035 When reset is high at a rising edge, the FIFO SHALL be emptied and the starve counter cleared.
REQ-036 When reset is high at a rising edge, regWrite, writeregister, data, pipe_stall, pend_mask and proto_err SHALL all become 0.
REQ-037 Reset SHALL discard in-flight entries and take priority over a simultaneous push or pop; unit_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-038 Pipe only: pipe_wr=1, reg 5, 0xDEADBEEF in cycle 3 -> regWrite=1, writeregister=5, data=0xDEADBEEF in cycle 4; regWrite=0 in cycle 5.
REQ-039 Unit idle path: accept reg 9, 0x1234 in cycle 2 -> pend_mask bit 9 set in cycle 3; write appears in cycle 4; pend_mask=0 in cycle 4.
REQ-040 Full FIFO: 4 unit accepts while pipe_wr=1 -> unit_ready=0; a 5th offer is held.
REQ-041 Drain order after pipe_wr drops: entries are written in acceptance order, and unit_ready returns to 1 after the first pop.
REQ-042 Starvation: FIFO holds 1 entry, pipe_wr=1 continuously -> pipe_stall=1 after 8 wait cycles plus 1; the head is written; pipe_stall=0 the next cycle; proto_err=1 if pipe_wr stays high.
REQ-043 Reset mid-operation: 3 entries queued and pipe_stall=1, reset pulsed for 1 cycle -> all outputs 0, unit_ready=1, no queued entry is ever written.
